// File: rtl/fp_sq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_sq_pkg
// Description : Shared constants, types and helpers for the fp_sq square
//               unit: IEEE-754 single special encodings, rounding-mode
//               codes, the exception-flag bundle and the round-increment
//               decision.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_sq_pkg;

    // IEEE-754 single-precision special encodings
    localparam logic [31:0] c_fp_infp = 32'h7F80_0000;  // +infinity
    localparam logic [31:0] c_fp_nanq = 32'h7FC0_0000;  // canonical quiet NaN
    localparam logic [31:0] c_fp_maxp = 32'h7F7F_FFFF;  // largest finite positive

    // Rounding-mode codes
    localparam logic [2:0] c_rm_rne = 3'd0;  // nearest, ties to even
    localparam logic [2:0] c_rm_rz  = 3'd1;  // toward zero
    localparam logic [2:0] c_rm_ru  = 3'd2;  // toward +infinity
    localparam logic [2:0] c_rm_rd  = 3'd3;  // toward -infinity
    localparam logic [2:0] c_rm_rna = 3'd4;  // nearest, ties away from zero

    typedef struct packed {
        logic ov;
        logic un;
        logic inv;
        logic inexact;
    } fp_flags_t;

    // Increment decision for a positive result (the square is never
    // negative, so RD behaves as RZ and RU rounds up on any discarded bit).
    function automatic logic round_incr(input logic [2:0] rm,
                                        input logic       g,
                                        input logic       t,
                                        input logic       lsb);
        case (rm)
            c_rm_rne: return g & (t | lsb);
            c_rm_ru:  return g | t;
            c_rm_rna: return g;
            default:  return 1'b0;  // RZ, RD and unknown codes truncate
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_sq_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_sq_if
// Description : Request/result bundle of the fp_sq unit.
//   act, in1, round_m        : request (master -> slave)
//   out, done, ov, un, inv,
//   inexact                  : result and flags (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_sq_if #(
    parameter int W = 32
);
    logic         act;
    logic [W-1:0] in1;
    logic [2:0]   round_m;
    logic [W-1:0] out;
    logic         done;
    logic         ov;
    logic         un;
    logic         inv;
    logic         inexact;

    modport master (
        output act, in1, round_m,
        input  out, done, ov, un, inv, inexact
    );

    modport slave (
        input  act, in1, round_m,
        output out, done, ov, un, inv, inexact
    );
endinterface
`default_nettype wire

// File: rtl/fp_sq_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul
// Description : Iterative radix-2 shift-add 24x24 unsigned multiplier.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   start : loads a/b, clears accumulator and counter
//   a, b  : 24-bit operands
//   p     : 48-bit product, final after the step that raises done
//   done  : high during the last (cnt = 23) step cycle
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start,
    input  wire logic [23:0] a,
    input  wire logic [23:0] b,
    output logic      [47:0] p,
    output logic             done
);

    localparam logic [4:0] c_last_step = 5'd23;

    logic        r_busy;
    logic [4:0]  r_cnt;
    logic [47:0] r_acc;
    logic [47:0] r_mcand;   // multiplicand, shifted left each step
    logic [23:0] r_mplier;  // multiplier, shifted right each step

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= 5'd0;
            r_acc    <= 48'd0;
            r_mcand  <= 48'd0;
            r_mplier <= 24'd0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= 5'd0;
            r_acc    <= 48'd0;
            r_mcand  <= {24'd0, a};
            r_mplier <= b;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 5'd1;
            if (r_cnt == c_last_step) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign p    = r_acc;
    assign done = r_busy && (r_cnt == c_last_step);

endmodule
`default_nettype wire

// File: rtl/fp_sq.sv
`default_nettype none
// ============================================================================
// Module      : fp_sq
// Description : IEEE-754 single-precision square, out = in1 * in1.
//               Result sign is always 0; subnormal inputs flush to zero,
//               underflow flushes to +0.
//   clk            : clock
//   rst            : asynchronous active-low reset
//   bus.act        : start, sampled only in IDLE
//   bus.in1        : operand, captured with act
//   bus.round_m    : rounding mode, captured with act
//   bus.out        : result, held until the next done
//   bus.done       : one-cycle pulse when out/flags update
//   bus.ov/un/inv/inexact : exception flags, valid with done, then held
// Revision    : 1.0 - initial release
// ============================================================================
module fp_sq
    import fp_sq_pkg::*;
#(
    parameter int W = 32,   // word width
    parameter int M = 22,   // MSB index of stored fraction
    parameter int E = 30    // MSB index of exponent field
) (
    input  wire logic clk,
    input  wire logic rst,
    fp_sq_if.slave    bus
);

    localparam int EW = E - M;  // exponent field width

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_rnd  = 2'd2;
    localparam logic [1:0] c_st_spec = 2'd3;

    logic [1:0]   r_state;
    logic [W-1:0] r_in1;
    logic [2:0]   r_rm;
    logic [W-1:0] r_out;
    logic         r_done;
    fp_flags_t    r_flags;

    // ---------------- operand classification at act -------------------
    logic [EW-1:0] w_in_exp;
    logic          w_in_special;
    logic          w_mul_start;
    logic [47:0]   w_p;
    logic          w_mul_done;

    assign w_in_exp     = bus.in1[E:M+1];
    // Exponent 0 (zero or subnormal) and exponent all-ones (inf/NaN)
    assign w_in_special = (w_in_exp == '0) || (&w_in_exp);
    assign w_mul_start  = (r_state == c_st_idle) && bus.act && !w_in_special;

    seq_mul u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (w_mul_start),
        .a     ({1'b1, bus.in1[M:0]}),
        .b     ({1'b1, bus.in1[M:0]}),
        .p     (w_p),
        .done  (w_mul_done)
    );

    // ---------------- special-operand result --------------------------
    logic [W-1:0] w_spec_out;
    fp_flags_t    w_spec_flags;

    always_comb begin
        w_spec_out   = '0;
        w_spec_flags = '0;
        if (r_in1[E:M+1] != '0) begin
            // only all-ones exponents reach here besides zero
            if (r_in1[M:0] == '0) begin
                w_spec_out = c_fp_infp;
            end else begin
                w_spec_out       = c_fp_nanq;
                w_spec_flags.inv = ~r_in1[M];  // signalling NaN
            end
        end
    end

    // ---------------- normalise, round, exponent, flags ---------------
    logic             w_norm;
    logic [M+1:0]     w_sig;
    logic             w_g;
    logic             w_t;
    logic [M+2:0]     w_sig_r;
    logic             w_carry;
    logic signed [9:0] w_er;
    logic [W-1:0]     w_rnd_out;
    fp_flags_t        w_rnd_flags;

    always_comb begin
        w_norm = w_p[47];
        if (w_norm) begin
            w_sig = w_p[47:24];
            w_g   = w_p[23];
            w_t   = |w_p[22:0];
        end else begin
            w_sig = w_p[46:23];
            w_g   = w_p[22];
            w_t   = |w_p[21:0];
        end
        w_sig_r = {1'b0, w_sig} + {{(M+2){1'b0}}, round_incr(r_rm, w_g, w_t, w_sig[0])};
        // A carry out leaves the stored fraction bits all zero, so only
        // the exponent needs adjusting.
        w_carry = w_sig_r[M+2];
        w_er    = {1'b0, r_in1[E:M+1], 1'b0} - 10'd127
                  + {9'd0, w_norm} + {9'd0, w_carry};

        w_rnd_flags         = '0;
        w_rnd_flags.inexact = w_g | w_t;
        w_rnd_out           = {1'b0, w_er[EW-1:0], w_sig_r[M:0]};
        if (w_er > 10'sd254) begin
            w_rnd_flags.ov      = 1'b1;
            w_rnd_flags.inexact = 1'b1;
            if ((r_rm == c_rm_rne) || (r_rm == c_rm_rna) || (r_rm == c_rm_ru)) begin
                w_rnd_out = c_fp_infp;
            end else begin
                w_rnd_out = c_fp_maxp;
            end
        end else if (w_er < 10'sd1) begin
            w_rnd_flags.un      = 1'b1;
            w_rnd_flags.inexact = 1'b1;
            w_rnd_out           = '0;
        end
    end

    // Operand sign and the hidden-bit position of the rounded significand
    // do not affect the square's encoding.
    logic w_unused;
    assign w_unused = r_in1[W-1] ^ w_sig_r[M+1];

    // ---------------- control FSM -------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
            r_in1   <= '0;
            r_rm    <= 3'd0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_flags <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.act) begin
                        r_in1   <= bus.in1;
                        r_rm    <= bus.round_m;
                        r_state <= w_in_special ? c_st_spec : c_st_mul;
                    end
                end
                c_st_mul: begin
                    if (w_mul_done) begin
                        r_state <= c_st_rnd;
                    end
                end
                c_st_rnd: begin
                    r_out   <= w_rnd_out;
                    r_flags <= w_rnd_flags;
                    r_done  <= 1'b1;
                    r_state <= c_st_idle;
                end
                c_st_spec: begin
                    r_out   <= w_spec_out;
                    r_flags <= w_spec_flags;
                    r_done  <= 1'b1;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign bus.out     = r_out;
    assign bus.done    = r_done;
    assign bus.ov      = r_flags.ov;
    assign bus.un      = r_flags.un;
    assign bus.inv     = r_flags.inv;
    assign bus.inexact = r_flags.inexact;

endmodule
`default_nettype wire
